debounce_edge_array: RTL and testbench



---
 rtl/debounce_edge_array.sv | 129 ++++++++++++
 tb/tb_debounce_edge_array.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge_array.sv
// debounce_edge_array: multi-channel switch debouncer with edge strobes and press toggle.
// Each channel has its own synchroniser, stability counter and registered strobes;
// channels never interact. Optional long-press strobe is built only when the macro
// DEBOUNCE_LONG_PRESS_EN is defined; otherwise o_Long_Press is tied to 0.
module debounce_edge_array #(
    parameter int unsigned NUM_CH           = 4,
    parameter int unsigned DEBOUNCE_LIMIT   = 250000,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned LONG_PRESS_LIMIT = 25000000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Toggle,
    output logic [NUM_CH-1:0] o_Long_Press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);
`else
    logic unused_long_press_limit;
    assign unused_long_press_limit = (LONG_PRESS_LIMIT == 0);
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   toggle_q, toggle_d;

        // Synchroniser chain for the raw asynchronous switch input.
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_Switch[ch]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Stability qualification: any agreement restarts the count.
        always_comb begin
            state_d  = state_q;
            cnt_d    = '0;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            toggle_d = toggle_q;
            if (s != state_q) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                    if (s) begin
                        toggle_d = ~toggle_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounced level, counter and strobes.
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                state_q  <= 1'b0;
                cnt_q    <= '0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                toggle_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                toggle_q <= toggle_d;
            end
        end

        assign o_Switch[ch] = state_q;
        assign o_Rise[ch]   = rise_q;
        assign o_Fall[ch]   = fall_q;
        assign o_Toggle[ch] = toggle_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;

        // Hold counter saturates at the limit so only one strobe fires per press.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (!state_q) begin
                hold_d = '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
                long_d = (hold_q == HOLD_LAST);
            end
        end

        // Hold counter and long-press strobe registers.
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign o_Long_Press[ch] = long_q;
`else
        assign o_Long_Press[ch] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_edge_array.sv
// tb_debounce_edge_array: directed scenarios plus random switch activity, checked every
// cycle against a window-based reference model of the debouncer.
module tb_debounce_edge_array;

    localparam int NCH  = 4;
    localparam int LIM  = 4;
    localparam int SYNC = 2;
    localparam int LP   = 10;
    localparam int H    = SYNC + LIM;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] sw_in;
    logic [NCH-1:0] sw_out, rise, fall, tog, longp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: raw-sample history per channel; the level flips when the
    // last LIM synchronised samples all disagree with it.
    logic [H-1:0]   m_hist [NCH];
    logic [NCH-1:0] m_state, m_toggle;
    logic [NCH-1:0] exp_rise, exp_fall, exp_long;
    int             m_rise_cyc [NCH];

    debounce_edge_array #(
        .NUM_CH          (NCH),
        .DEBOUNCE_LIMIT  (LIM),
        .SYNC_STAGES     (SYNC),
        .LONG_PRESS_LIMIT(LP)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Switch    (sw_in),
        .o_Switch    (sw_out),
        .o_Rise      (rise),
        .o_Fall      (fall),
        .o_Toggle    (tog),
        .o_Long_Press(longp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_hist[c]     = '0;
            m_rise_cyc[c] = -100000;
        end
        m_state  = '0;
        m_toggle = '0;
        exp_rise = '0;
        exp_fall = '0;
        exp_long = '0;
    endtask

    task automatic model_step(input logic [NCH-1:0] raw);
        logic flip;
        exp_rise = '0;
        exp_fall = '0;
        exp_long = '0;
        for (int c = 0; c < NCH; c++) begin
            m_hist[c] = {m_hist[c][H-2:0], raw[c]};
            flip = (m_hist[c][H-1:SYNC] == {LIM{~m_state[c]}});
            if (flip) begin
                m_state[c] = ~m_state[c];
                if (m_state[c]) begin
                    exp_rise[c]   = 1'b1;
                    m_toggle[c]   = ~m_toggle[c];
                    m_rise_cyc[c] = cyc;
                end else begin
                    exp_fall[c] = 1'b1;
                end
            end
`ifdef DEBOUNCE_LONG_PRESS_EN
            exp_long[c] = m_state[c] && (cyc - m_rise_cyc[c] == LP);
`endif
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sw"},   32'(sw_out), 32'(m_state));
        check({tag, ".rise"}, 32'(rise),   32'(exp_rise));
        check({tag, ".fall"}, 32'(fall),   32'(exp_fall));
        check({tag, ".tog"},  32'(tog),    32'(m_toggle));
        check({tag, ".long"}, 32'(longp),  32'(exp_long));
    endtask

    // One clock: model consumes the input seen at the edge, outputs sampled 1ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        cyc++;
        model_step(sw_in);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all({tag, ".held"});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycles from now until o_Switch[ch] rises, bounded.
    task automatic measure(input int ch, input string tag);
        int n;
        n = 0;
        while (n < 20 && !sw_out[ch]) begin
            tick(tag);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(SYNC + LIM));
    endtask

    initial begin
        sw_in = '0;
        rst_n = 1'b1;
        model_reset();
        #2;
        do_reset("rst0");
        repeat (3) tick("idle");

        // Clean step on ch0.
        sw_in[0] = 1'b1;
        measure(0, "ch0");
        repeat (3) tick("ch0_hold");

        // Bounce on ch1.
        sw_in[1] = 1'b1;
        repeat (3) tick("ch1_b");
        sw_in[1] = 1'b0;
        tick("ch1_b");
        sw_in[1] = 1'b1;
        measure(1, "ch1");

        // Two press/release cycles on ch2.
        repeat (2) begin
            sw_in[2] = 1'b1;
            repeat (8) tick("ch2_p");
            sw_in[2] = 1'b0;
            repeat (8) tick("ch2_r");
        end
        check("ch2.tog_final", 32'(tog[2]), 32'd0);

        // Long hold, release, re-press on ch0.
        repeat (12) tick("ch0_long");
        sw_in[0] = 1'b0;
        repeat (8) tick("ch0_rel");
        sw_in[0] = 1'b1;
        repeat (25) tick("ch0_repress");

        // Reset mid-count on ch3.
        sw_in[3] = 1'b1;
        repeat (4) tick("ch3_cnt");
        do_reset("rst3");
        measure(3, "ch3");
        repeat (4) tick("ch3_hold");

        // Random activity with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) sw_in[c] = ~sw_in[c];
            end
            if (i == 1500) do_reset("rst_rand");
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
